uart_tx_mmio: RTL and testbench

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_tx_mmio.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/DIV registers feeding a small FIFO and 8N1 serialiser.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
module uart_tx_mmio #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        busy_o
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  A_TXDATA = 4'h0;
    localparam logic [3:0]  A_STATUS = 4'h4;
    localparam logic [3:0]  A_DIV    = 4'h8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [15:0]   div_reg;
    logic [15:0]   period;
    logic [15:0]   tick_cnt;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit;
`endif

    logic          full;
    logic          empty;
    logic          tick_end;
    logic          push_req;
    logic          push;
    logic          pop;
    logic [15:0]   eff_div;
    logic          unused_wdata;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign tick_end     = (tick_cnt == period - 16'd1);
    assign eff_div      = (div_reg < 16'd2) ? 16'd2 : div_reg;
    assign push_req     = we_i && (addr_i == A_TXDATA);
    // A frame may be fetched from IDLE or straight out of STOP, giving gapless back-to-back frames.
    assign pop          = !empty && ((state == IDLE) || ((state == STOP) && tick_end));
    assign push         = push_req && (!full || pop);
    assign busy_o       = (state != IDLE) || !empty;
    assign unused_wdata = ^wdata_i[31:16];

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            A_STATUS: rdata_o = {24'd0, 4'(count), overflow, busy_o, empty, full};
            A_DIV:    rdata_o = {16'd0, div_reg};
            default:  rdata_o = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg  <= 16'(CLK_DIV);
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (we_i && (addr_i == A_DIV))
                div_reg <= wdata_i[15:0];
            if (push_req && !push)
                overflow <= 1'b1;
            else if (we_i && (addr_i == A_STATUS) && wdata_i[3])
                overflow <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // NOTE: FIFO storage is not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= wdata_i[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_o      <= 1'b1;
            tick_cnt  <= '0;
            period    <= 16'd2;
            shift_reg <= '0;
            bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tick_cnt <= (state == IDLE || tick_end) ? 16'd0 : tick_cnt + 16'd1;
            if (pop) begin
                state     <= START;
                tx_o      <= 1'b0;
                shift_reg <= mem[rd_ptr];
                period    <= eff_div;
                tick_cnt  <= 16'd0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^mem[rd_ptr];
`endif
            end else begin
                case (state)
                    START: if (tick_end) begin
                        state     <= DATA;
                        tx_o      <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_cnt   <= 3'd0;
                    end
                    DATA: if (tick_end) begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx_o  <= parity_bit;
`else
                            state <= STOP;
                            tx_o  <= 1'b1;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            tx_o      <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: if (tick_end) begin
                        state <= STOP;
                        tx_o  <= 1'b1;
                    end
`endif
                    STOP: if (tick_end) begin
                        state <= IDLE;
                        tx_o  <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        tx_o  <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed + randomized bench for uart_tx_mmio; line waveform predicted from frame rules.
module tb_uart_tx_mmio;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        we    = 1'b0;
    logic [3:0]  addr  = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    int          vectors = 0;
    int          errors  = 0;
    logic [7:0]  q[$];
    logic [7:0]  bytes[10];
    logic [7:0]  b;
    int          dv;

    uart_tx_mmio dut (
        .clk(clk), .rst(rst), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata), .tx_o(tx), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line level of bit slot j within a frame carrying byte v.
    function automatic logic model_bit(input logic [7:0] v, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return v[j-1];
        if (FB == 11 && j == 9) return ^v;
        return 1'b1;
    endfunction

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    // Called at the negedge that corresponds to sample k0 of a gapless frame stream.
    task automatic expect_stream(input logic [7:0] fq[$], input int div_w, input int k0,
                                 input int mid_k, input logic [15:0] mid_div);
        int d;
        int flen;
        int total;
        d     = (div_w < 2) ? 2 : div_w;
        flen  = FB * d;
        total = flen * fq.size();
        for (int k = k0; k < total; k++) begin
            if (k != k0) @(negedge clk);
            check($sformatf("tx f%0d c%0d", k / flen, k % flen), 32'(tx),
                  32'(model_bit(fq[k / flen], (k % flen) / d)));
            check($sformatf("busy f%0d c%0d", k / flen, k % flen), 32'(busy), 32'd1);
            if (k == mid_k) begin
                we = 1'b1; addr = 4'h8; wdata = {16'd0, mid_div};
            end else if (k == mid_k + 1) begin
                we = 1'b0;
            end
        end
        @(negedge clk);
        check("tx idle after frames", 32'(tx), 32'd1);
        check("busy low after frames", 32'(busy), 32'd0);
    endtask

    task automatic send_one(input logic [7:0] v, input int div_w);
        logic [7:0] one[$];
        one = {v};
        write_reg(4'h0, {24'd0, v});
        @(negedge clk);
        expect_stream(one, div_w, 0, -1, 16'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        read_chk("reset status", 4'h4, 32'h2);
        read_chk("reset div", 4'h8, 32'd868);
        read_chk("txdata reads 0", 4'h0, 32'h0);

        // Single 0x55 frame at DIV=4
        write_reg(4'h8, 32'd4);
        read_chk("div readback 4", 4'h8, 32'd4);
        send_one(8'h55, 4);
        read_chk("status idle after 0x55", 4'h4, 32'h2);

        // Two consecutive writes give back-to-back frames
        @(negedge clk);
        we = 1'b1; addr = 4'h0; wdata = 32'h41;
        @(negedge clk);
        wdata = 32'h42;
        @(negedge clk);
        we = 1'b0;
        q = {8'h41, 8'h42};
        expect_stream(q, 4, 0, -1, 16'd0);

        // Random bytes and divisors, including 0 and 1 which act as 2
        for (int i = 0; i < 4; i++) begin
            b  = 8'($urandom);
            dv = int'($urandom_range(0, 6));
            write_reg(4'h8, 32'(dv));
            read_chk($sformatf("div readback r%0d", i), 4'h8, 32'(dv));
            send_one(b, dv);
        end

        // DIV written mid-frame only affects the following frame
        write_reg(4'h8, 32'd3);
        b = 8'($urandom);
        write_reg(4'h0, {24'd0, b});
        @(negedge clk);
        q = {b};
        expect_stream(q, 3, 0, 10, 16'd5);
        read_chk("div after mid-frame write", 4'h8, 32'd5);
        send_one(8'($urandom), 5);

        // Fill FIFO behind an in-flight frame; tenth byte is dropped
        write_reg(4'h8, 32'd2);
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            we = 1'b1; addr = 4'h0; wdata = {24'd0, bytes[i]};
            @(negedge clk);
        end
        we = 1'b0;
        read_chk("status full+overflow", 4'h4, 32'h8D);
        q = {};
        for (int i = 0; i < 9; i++) q.push_back(bytes[i]);
        expect_stream(q, 2, 8, -1, 16'd0);
        read_chk("status sticky overflow", 4'h4, 32'hA);
        write_reg(4'h4, 32'h8);
        read_chk("status overflow cleared", 4'h4, 32'h2);

        // Unmapped addresses
        write_reg(4'hC, 32'h1234);
        read_chk("unmapped reads 0", 4'hC, 32'h0);
        read_chk("div unchanged by unmapped write", 4'h8, 32'd2);

        // Stalled line: full, overflow, then clear
        write_reg(4'h8, 32'hFFFF);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            we = 1'b1; addr = 4'h0; wdata = 32'(i);
            @(negedge clk);
        end
        we = 1'b0;
        read_chk("stalled status full", 4'h4, 32'h8D);
        write_reg(4'h4, 32'h8);
        read_chk("stalled overflow cleared", 4'h4, 32'h85);

        // Reset discards the queue and aborts the frame
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset flush tx", 32'(tx), 32'd1);
        read_chk("reset flush status", 4'h4, 32'h2);
        read_chk("reset flush div", 4'h8, 32'd868);

        // Reset during data bit 3, with a write during reset
        write_reg(4'h8, 32'd4);
        write_reg(4'h0, 32'hF0);
        @(negedge clk);
        for (int k = 0; k < 17; k++) begin
            if (k != 0) @(negedge clk);
            check($sformatf("pre-reset tx c%0d", k), 32'(tx), 32'(model_bit(8'hF0, k / 4)));
        end
        @(negedge clk);
        rst = 1'b1; we = 1'b1; addr = 4'h0; wdata = 32'h5A;
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        check("mid-frame reset tx", 32'(tx), 32'd1);
        check("mid-frame reset busy", 32'(busy), 32'd0);
        read_chk("mid-frame reset status", 4'h4, 32'h2);
        read_chk("mid-frame reset div", 4'h8, 32'd868);
        repeat (3) @(negedge clk);
        check("line stays idle after reset", 32'(tx), 32'd1);
        check("busy stays low after reset", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
